register_n: RTL and testbench
=============================

REGISTER_N -- requirements
Module: register_n

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (WIDTH >= 2).
REQ-002 Parameter SHW, default 3, width of the shift-amount port; shift counts above WIDTH-1 are legal.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cl  in  1  clear register to zero.
REQ-006 ld  in  1  parallel load from in.
REQ-007 in  in  WIDTH  parallel load data.
REQ-008 inc / dec  in  1 each  count up / count down by one.
REQ-009 sr / sl  in  1 each  single-bit shift right / left.
REQ-010 ir / il  in  1 each  serial bit inserted on right / left shift (logical mode).
REQ-011 mode  in  2  shift mode: 00 logical, 01 arithmetic, 10 rotate, 11 treated as logical.
REQ-012 start  in  1  launch multi-cycle shift; dir  in  1  direction, 0 right, 1 left; shamt  in  SHW  shift count.
REQ-013 out  out  WIDTH  register contents.
REQ-014 busy  out  1  multi-cycle shift in progress; done  out  1  one-cycle completion pulse; co  out  1  one-cycle carry/borrow pulse.

Function
REQ-015 FSM states IDLE and SHIFT; in IDLE, command priority: cl > ld > start > inc > dec > sr > sl; no command holds out.
REQ-016 inc: out <= out+1 modulo 2^WIDTH; co = 1 the next cycle only if prior out was all ones.
REQ-017 dec: out <= out-1 modulo 2^WIDTH; co = 1 the next cycle only if prior out was zero.
REQ-018 Right shift: MSB fill = ir (logical), out[WIDTH-1] (arithmetic), out[0] (rotate).
REQ-019 Left shift: LSB fill = il (logical), 0 (arithmetic), out[WIDTH-1] (rotate).
REQ-020 start with shamt = k > 0 at edge t0: latch dir, mode, ir, il, k; enter SHIFT; busy = 1 from t0 to tk; one bit shifted at each edge t1..tk; IDLE after tk.
REQ-021 done = 1 exactly in the cycle following tk; out holds the final result in that cycle.
REQ-022 start with shamt = 0: no state change to SHIFT, out unchanged, busy stays 0, done pulses in the next cycle.
REQ-023 In SHIFT, ld, start, inc, dec, sr, sl ignored; changes to mode/dir/ir/il have no effect.
REQ-024 cl in SHIFT aborts: out <= 0, IDLE next cycle, busy <= 0, no done pulse.
REQ-025 co and done are never asserted together with an ignored command; both are 0 in every cycle not specified above.

Reset
REQ-026 rst sampled high at a rising edge: out = 0, busy = 0, done = 0, co = 0, state IDLE, internal counter 0; rst overrides every other input, including mid-shift.
REQ-027 First command after rst deasserts is honoured at the next rising edge.

Structure
REQ-028 Shared package holds mode encodings (LOGICAL, ARITH, ROTATE) and the FSM state enumeration.
REQ-029 One sub-module, shift_step: combinational single-bit shift of WIDTH bits given dir, mode, fill bit; used by both single shifts and SHIFT state.
REQ-030 Remaining-count register is SHW bits; no other counters.

Verification (WIDTH = 8)
REQ-031 rst = 1 with ld = 1, in = 8'hA5 -> out = 8'h00, busy/done/co = 0.
REQ-032 ld 8'hFF, then inc -> out = 8'h00, co = 1 for one cycle; dec -> out = 8'hFF, co = 1 for one cycle.
REQ-033 ld 8'h96, start dir = 0 mode = 01 shamt = 3 -> busy high 3 cycles, out = 8'hF2, done high 1 cycle.
REQ-034 ld 8'h3C, start dir = 1 mode = 10 shamt = 4 -> out = 8'hC3 after 4 shifts; inc asserted during busy has no effect.
REQ-035 cl asserted on second SHIFT cycle -> out = 8'h00, busy = 0 next cycle, done never asserted.
REQ-036 cl+ld+inc simultaneous -> out = 0; ld (in = 8'h12) + inc -> out = 8'h12; start shamt = 0 -> out unchanged, done pulse, busy 0.

Source files
------------

// File: rtl/register_n_pkg.sv
// Shared definitions for register_n: shift-mode encodings, FSM states and the
// latched multi-cycle shift job.
package register_n_pkg;

  localparam logic [1:0] LOGICAL = 2'b00;
  localparam logic [1:0] ARITH   = 2'b01;
  localparam logic [1:0] ROTATE  = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Parameters of a multi-cycle shift, frozen when it launches
  typedef struct packed {
    logic       dir;
    logic [1:0] mode;
    logic       fill;
  } shift_job_t;

endpackage

// File: rtl/register_n_shift_step.sv
// Combinational single-bit shift of a WIDTH-bit word; dir 0 = right, 1 = left.
// Mode 11 falls through to logical behaviour.
module shift_step
  import register_n_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] q_c
);

  logic msb_fill;
  logic lsb_fill;

  always_comb begin
    msb_fill = fill;
    lsb_fill = fill;
    case (mode)
      LOGICAL: ;
      ARITH: begin
        msb_fill = d[WIDTH-1];
        lsb_fill = 1'b0;
      end
      ROTATE: begin
        msb_fill = d[0];
        lsb_fill = d[WIDTH-1];
      end
      default: ;
    endcase
    q_c = dir ? {d[WIDTH-2:0], lsb_fill} : {msb_fill, d[WIDTH-1:1]};
  end

endmodule

// File: rtl/register_n.sv
// Multi-function register: clear, load, count, single-bit shifts and a
// multi-cycle shift sequenced by a two-state FSM.
module register_n
  import register_n_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cl,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  input  logic             sr,
  input  logic             sl,
  input  logic             ir,
  input  logic             il,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             dir,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             co
);

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  shift_job_t       job_q, job_d;
  logic [WIDTH-1:0] out_d;
  logic             busy_d, done_d, co_d;

  logic             step_dir;
  logic [1:0]       step_mode;
  logic             step_fill;
  logic [WIDTH-1:0] shifted_c;

  // Shifter operands: frozen job while sequencing, live inputs otherwise
  always_comb begin
    step_dir  = ~sr;
    step_mode = mode;
    step_fill = sr ? ir : il;
    if (state_q == SHIFT) begin
      step_dir  = job_q.dir;
      step_mode = job_q.mode;
      step_fill = job_q.fill;
    end
  end

  shift_step #(.WIDTH(WIDTH)) u_shift_step (
    .d    (out),
    .dir  (step_dir),
    .mode (step_mode),
    .fill (step_fill),
    .q_c  (shifted_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      job_q   <= '0;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      co      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      job_q   <= job_d;
      out     <= out_d;
      busy    <= busy_d;
      done    <= done_d;
      co      <= co_d;
    end
  end

  // Next state, register contents and status pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    job_d   = job_q;
    out_d   = out;
    busy_d  = busy;
    done_d  = 1'b0;
    co_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cl) begin
          out_d = '0;
        end else if (ld) begin
          out_d = in;
        end else if (start) begin
          if (shamt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = SHIFT;
            busy_d     = 1'b1;
            cnt_d      = shamt;
            job_d.dir  = dir;
            job_d.mode = mode;
            job_d.fill = dir ? il : ir;
          end
        end else if (inc) begin
          out_d = out + WIDTH'(1);
          co_d  = &out;
        end else if (dec) begin
          out_d = out - WIDTH'(1);
          co_d  = ~|out;
        end else if (sr || sl) begin
          out_d = shifted_c;
        end
      end
      SHIFT: begin
        if (cl) begin
          out_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          out_d = shifted_c;
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_register_n.sv
// Bench for register_n (WIDTH = 8): directed literal checks plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_register_n;

  logic       clk = 1'b0;
  logic       rst, cl, ld, inc, dec, sr, sl, ir, il, start, dir;
  logic [7:0] in;
  logic [1:0] mode;
  logic [2:0] shamt;
  logic [7:0] out;
  logic       busy, done, co;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  int m_out = 0, m_busy = 0, m_done = 0, m_co = 0;
  int m_left = 0, m_dir = 0, m_mode = 0, m_fill = 0;

  register_n #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst(rst), .cl(cl), .ld(ld), .in(in), .inc(inc), .dec(dec),
    .sr(sr), .sl(sl), .ir(ir), .il(il), .mode(mode), .start(start),
    .dir(dir), .shamt(shamt), .out(out), .busy(busy), .done(done), .co(co)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // One-bit shift of an 8-bit value from the mode rules
  function automatic int shift1(input int v, input int d, input int md, input int f);
    int msb, lsb;
    msb = f;
    lsb = f;
    if (md == 1) begin msb = (v >> 7) & 1; lsb = 0; end
    if (md == 2) begin msb = v & 1; lsb = (v >> 7) & 1; end
    if (d == 0) return (v >> 1) | (msb << 7);
    return ((v << 1) & 255) | lsb;
  endfunction

  always @(posedge clk) begin
    m_done = 0;
    m_co   = 0;
    if (rst) begin
      m_out = 0; m_busy = 0; m_left = 0;
    end else if (m_left > 0) begin
      if (cl) begin
        m_out = 0; m_left = 0; m_busy = 0;
      end else begin
        m_out  = shift1(m_out, m_dir, m_mode, m_fill);
        m_left = m_left - 1;
        if (m_left == 0) begin m_busy = 0; m_done = 1; end
      end
    end else if (cl) m_out = 0;
    else if (ld) m_out = int'(in);
    else if (start) begin
      if (shamt == 0) m_done = 1;
      else begin
        m_left = int'(shamt); m_busy = 1;
        m_dir = int'(dir); m_mode = int'(mode); m_fill = dir ? int'(il) : int'(ir);
      end
    end else if (inc) begin
      m_co = (m_out == 255); m_out = (m_out + 1) % 256;
    end else if (dec) begin
      m_co = (m_out == 0); m_out = (m_out + 255) % 256;
    end else if (sr) m_out = shift1(m_out, 0, int'(mode), int'(ir));
    else if (sl) m_out = shift1(m_out, 1, int'(mode), int'(il));
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_out", 32'(out), 32'(m_out));
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_done", 32'(done), 32'(m_done));
      check("model_co", 32'(co), 32'(m_co));
    end
  end

  task automatic quiet();
    rst = 0; cl = 0; ld = 0; inc = 0; dec = 0; sr = 0; sl = 0; start = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    quiet();
    ir = 0; il = 0; dir = 0; mode = 0; shamt = 0; in = 8'h00;
    // Reset wins over a simultaneous load
    rst = 1; ld = 1; in = 8'hA5;
    cyc(2);
    cmp_en = 1'b1;
    check("rst_out", 32'(out), 32'h00);
    check("rst_flags", {busy, done, co}, 3'b000);

    // Wrap-around with carry/borrow
    quiet(); ld = 1; in = 8'hFF; cyc(1);
    quiet(); inc = 1; cyc(1);
    quiet(); check("inc_wrap", 32'(out), 32'h00); check("inc_co", 32'(co), 1);
    cyc(1); check("inc_co_drop", 32'(co), 0);
    dec = 1; cyc(1);
    quiet(); check("dec_wrap", 32'(out), 32'hFF); check("dec_co", 32'(co), 1);
    cyc(1); check("dec_co_drop", 32'(co), 0);

    // Arithmetic right by 3
    ld = 1; in = 8'h96; cyc(1);
    quiet(); start = 1; dir = 0; mode = 2'b01; shamt = 3; cyc(1);
    quiet();
    for (int i = 0; i < 3; i++) begin check("ashr_busy", 32'(busy), 1); cyc(1); end
    check("ashr_out", 32'(out), 32'hF2); check("ashr_done", 32'(done), 1);
    check("ashr_busy_end", 32'(busy), 0);
    cyc(1); check("ashr_done_drop", 32'(done), 0);

    // Rotate left by 4, ignoring inc and mode/dir changes while busy
    ld = 1; in = 8'h3C; cyc(1);
    quiet(); start = 1; dir = 1; mode = 2'b10; shamt = 4; cyc(1);
    quiet(); inc = 1; mode = 2'b00; dir = 0; cyc(3);
    quiet(); cyc(1);
    check("rotl_out", 32'(out), 32'hC3); check("rotl_done", 32'(done), 1);
    check("rotl_co", 32'(co), 0);
    cyc(1);

    // Clear aborts on the second shift cycle
    ld = 1; in = 8'h5A; cyc(1);
    quiet(); start = 1; dir = 0; mode = 2'b00; ir = 1; shamt = 5; cyc(1);
    quiet(); cyc(1);
    cl = 1; cyc(1);
    quiet();
    check("abort_out", 32'(out), 32'h00); check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    cyc(3);

    // Priority and zero-length shift
    ld = 1; in = 8'h77; cyc(1);
    quiet(); cl = 1; ld = 1; inc = 1; in = 8'h55; cyc(1);
    quiet(); check("prio_cl", 32'(out), 32'h00);
    ld = 1; inc = 1; in = 8'h12; cyc(1);
    quiet(); check("prio_ld", 32'(out), 32'h12);
    start = 1; shamt = 0; cyc(1);
    quiet(); check("zero_out", 32'(out), 32'h12); check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    cyc(1);

    // Reset mid-shift, then the first command is honoured
    start = 1; shamt = 7; dir = 1; mode = 2'b00; il = 1; cyc(1);
    quiet(); cyc(2);
    rst = 1; cyc(1);
    quiet(); check("rst_mid_out", 32'(out), 32'h00); check("rst_mid_busy", 32'(busy), 0);
    ld = 1; in = 8'hC7; cyc(1);
    quiet(); check("post_rst_ld", 32'(out), 32'hC7);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(199) == 0);
      cl    = ($urandom_range(39) == 0);
      ld    = ($urandom_range(9) == 0);
      start = ($urandom_range(7) == 0);
      inc   = ($urandom_range(4) == 0);
      dec   = ($urandom_range(4) == 0);
      sr    = ($urandom_range(3) == 0);
      sl    = ($urandom_range(3) == 0);
      ir    = 1'($urandom_range(1));
      il    = 1'($urandom_range(1));
      dir   = 1'($urandom_range(1));
      mode  = 2'($urandom_range(3));
      shamt = 3'($urandom_range(7));
      in    = 8'($urandom);
      cyc(1);
    end
    quiet();
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
